sync_updown_counter: RTL and testbench

//  - Fully synchronous, cascadable modulo-N up/down counter with parallel load.
//  - Synchronous counterpart to the team's ripple T-flop counters. All bits

---
 rtl/sync_updown_counter_pkg.sv | 20 ++
 rtl/sync_updown_counter_tff.sv | 20 ++
 rtl/sync_updown_counter.sv | 98 +++++++++
 tb/tb_sync_updown_counter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sync_updown_counter_pkg.sv
// Helper functions shared by the synchronous up/down counter.
// Arguments are 32 bits wide so one definition serves every WIDTH up to 32;
// callers zero-extend their operands and truncate the result back.
package sync_updown_counter_pkg;

  // Limit a parallel-load value to the top of the count range.
  function automatic logic [31:0] clamp_load(input logic [31:0] din,
                                             input logic [31:0] max_val);
    return (din > max_val) ? max_val : din;
  endfunction

  // True when q sits at the end of the range in the current direction:
  // MAX when counting up, zero when counting down.
  function automatic logic at_terminal(input logic [31:0] q,
                                       input logic        up,
                                       input logic [31:0] max_val);
    return up ? (q == max_val) : (q == 32'd0);
  endfunction

endpackage

// File: rtl/sync_updown_counter_tff.sv
// Single synchronous T flip-flop: one bit of the counter.
// Clear wins over toggle; every cell shares the same clock edge, so all
// counter bits change together.
module sync_tff_cell (
  input  logic clk,
  input  logic clear,
  input  logic t,
  output logic q
);

  // Synchronous clear to 0, otherwise invert when t is high.
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/sync_updown_counter.sv
// Fully synchronous modulo-MODULUS up/down counter with parallel load.
// Priority on each edge: clear > load > en > hold.
// The next count is computed as a whole value and turned into per-bit toggle
// requests for the T cells, so the end-of-range behaviour (wrap to 0 / MAX or
// saturate) is an explicit load rather than natural binary overflow.
// tc is combinational and is meant to drive the en of the next stage up.
module sync_updown_counter
  import sync_updown_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrapped
);

  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
  localparam logic [31:0]      MAX32 = 32'(MAX);

  // Elaboration-time sanity check of the parameter set.
  initial begin
    if (WIDTH < 1 || WIDTH > 32) begin
      $error("sync_updown_counter: WIDTH=%0d out of range 1..32", WIDTH);
    end
    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin
      $error("sync_updown_counter: MODULUS=%0d out of range 2..2**%0d",
             MODULUS, WIDTH);
    end
  end

  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] toggle;
  logic             wrap_next;

  // Next-count logic: load clamps, counting wraps or saturates at the ends.
  always_comb begin
    next_q    = q;
    wrap_next = 1'b0;
    if (load) begin
      next_q = WIDTH'(clamp_load(32'(din), MAX32));
    end else if (en) begin
      if (up) begin
        if (q == MAX) begin
          if (!SATURATE) begin
            next_q    = '0;
            wrap_next = 1'b1;
          end
        end else begin
          next_q = q + WIDTH'(1);
        end
      end else begin
        if (q == '0) begin
          if (!SATURATE) begin
            next_q    = MAX;
            wrap_next = 1'b1;
          end
        end else begin
          next_q = q - WIDTH'(1);
        end
      end
    end
  end

  // A bit toggles exactly where the next count differs from the current one.
  assign toggle = q ^ next_q;

  // One T cell per counter bit; clear is applied inside each cell.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sync_tff_cell u_bit (
      .clk  (clk),
      .clear(clear),
      .t    (toggle[i]),
      .q    (q[i])
    );
  end

  // Wrap pulse: high for the one cycle following a wrap-around edge.
  always_ff @(posedge clk) begin
    if (clear) begin
      wrapped <= 1'b0;
    end else begin
      wrapped <= wrap_next;
    end
  end

  // Terminal count marks "at the end in the current direction" even when
  // saturating; it depends only on q, en and up.
  assign tc = en & at_terminal(32'(q), up, MAX32);

endmodule

// File: tb/tb_sync_updown_counter.sv
// Bench for sync_updown_counter.
// Three single counters (mod 16 wrap, mod 10 saturate, mod 10 wrap) are driven
// from a table of {inputs, expected tc before the edge, expected q / wrapped
// after the edge}. A two-stage cascade is then run for 300 edges and compared
// against the edge count.
module tb_sync_updown_counter;

  // ---------------- clock ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- single-counter DUTs (0: mod16 wrap, 1: mod10 sat, 2: mod10 wrap)
  logic       clear_a   [3];
  logic       en_a      [3];
  logic       up_a      [3];
  logic       load_a    [3];
  logic [3:0] din_a     [3];
  logic [3:0] q_a       [3];
  logic       tc_a      [3];
  logic       wrapped_a [3];

  sync_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_def (
    .clk(clk), .clear(clear_a[0]), .en(en_a[0]), .up(up_a[0]), .load(load_a[0]),
    .din(din_a[0]), .q(q_a[0]), .tc(tc_a[0]), .wrapped(wrapped_a[0])
  );

  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
    .clk(clk), .clear(clear_a[1]), .en(en_a[1]), .up(up_a[1]), .load(load_a[1]),
    .din(din_a[1]), .q(q_a[1]), .tc(tc_a[1]), .wrapped(wrapped_a[1])
  );

  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_m10 (
    .clk(clk), .clear(clear_a[2]), .en(en_a[2]), .up(up_a[2]), .load(load_a[2]),
    .din(din_a[2]), .q(q_a[2]), .tc(tc_a[2]), .wrapped(wrapped_a[2])
  );

  // ---------------- cascade: hi.en = lo.tc ----------------
  logic       c_clear = 1'b1;
  logic       c_en    = 1'b0;
  logic       c_up    = 1'b1;
  logic       c_load  = 1'b0;
  logic [3:0] c_din   = 4'd0;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_w, hi_w;

  sync_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_lo (
    .clk(clk), .clear(c_clear), .en(c_en), .up(c_up), .load(c_load),
    .din(c_din), .q(lo_q), .tc(lo_tc), .wrapped(lo_w)
  );

  sync_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_hi (
    .clk(clk), .clear(c_clear), .en(lo_tc), .up(c_up), .load(c_load),
    .din(c_din), .q(hi_q), .tc(hi_tc), .wrapped(hi_w)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         sel;
    logic       clear;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din;
    logic       exp_tc;   // before the edge, with these inputs applied
    logic [3:0] exp_q;    // after the edge
    logic       exp_w;    // after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int sel, input bit cl, input bit en, input bit up,
                     input bit ld, input int din, input bit tc, input int q,
                     input bit w);
    vec_t v;
    v.sel = sel; v.clear = cl; v.en = en; v.up = up; v.load = ld;
    v.din = 4'(din); v.exp_tc = tc; v.exp_q = 4'(q); v.exp_w = w;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic apply_vec(input int idx, input vec_t v);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      clear_a[k] = 1'b0; en_a[k] = 1'b0; up_a[k] = 1'b1;
      load_a[k]  = 1'b0; din_a[k] = 4'd0;
    end
    clear_a[v.sel] = v.clear;
    en_a[v.sel]    = v.en;
    up_a[v.sel]    = v.up;
    load_a[v.sel]  = v.load;
    din_a[v.sel]   = v.din;
    #1;
    check($sformatf("v%0d dut%0d tc", idx, v.sel), 32'(tc_a[v.sel]), 32'(v.exp_tc));
    @(posedge clk);
    #1;
    check($sformatf("v%0d dut%0d q", idx, v.sel), 32'(q_a[v.sel]), 32'(v.exp_q));
    check($sformatf("v%0d dut%0d wrapped", idx, v.sel), 32'(wrapped_a[v.sel]), 32'(v.exp_w));
  endtask

  // ---------------- test ----------------
  initial begin
    for (int k = 0; k < 3; k++) begin
      clear_a[k] = 1'b1; en_a[k] = 1'b0; up_a[k] = 1'b1;
      load_a[k]  = 1'b0; din_a[k] = 4'd0;
    end

    // sel, clear, en, up, load, din, tc, q, wrapped
    // Reset then count up through the wrap (mod 16).
    add(0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++)
      add(0, 0, 1, 1, 0, 0, (i % 16) == 15, (i + 1) % 16, i == 15);
    // Clear with up=0/en=1, then count down from zero (q was 2).
    add(0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 15, 1);
    add(0, 0, 1, 0, 0, 0, 0, 14, 0);
    add(0, 0, 1, 0, 0, 0, 0, 13, 0);
    add(0, 0, 1, 0, 0, 0, 0, 12, 0);
    // Mid-run direction change and enable low.
    add(0, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 1, 1, 0, 0, 0, i + 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 4, 0);
    add(0, 0, 0, 0, 0, 0, 0, 4, 0);
    add(0, 0, 0, 0, 0, 0, 0, 4, 0);
    add(0, 0, 0, 0, 0, 0, 0, 4, 0);
    // Loads beat counting; load at MAX with en suppresses the wrap.
    add(0, 0, 1, 0, 1, 12, 0, 12, 0);
    add(0, 0, 1, 1, 1, 15, 0, 15, 0);
    add(0, 0, 1, 1, 1, 3, 1, 3, 0);
    add(0, 0, 0, 1, 1, 15, 0, 15, 0);
    add(0, 0, 1, 1, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Saturating mod 10.
    add(1, 1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 8, 0, 8, 0);
    add(1, 0, 1, 1, 0, 0, 0, 9, 0);
    add(1, 0, 1, 1, 0, 0, 1, 9, 0);
    add(1, 0, 1, 1, 0, 0, 1, 9, 0);
    add(1, 0, 1, 1, 0, 0, 1, 9, 0);
    // Load clamp and priority.
    add(1, 0, 0, 1, 1, 13, 0, 9, 0);
    add(1, 0, 1, 1, 1, 3, 1, 3, 0);
    add(1, 1, 1, 1, 1, 7, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 1, 1, 10, 0, 9, 0);
    add(1, 0, 0, 1, 1, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 9, 0, 9, 0);
    add(1, 0, 1, 0, 0, 0, 0, 8, 0);

    // Wrapping mod 10: wrap happens at 9, not at 15.
    add(2, 1, 0, 1, 0, 0, 0, 0, 0);
    add(2, 0, 0, 1, 1, 8, 0, 8, 0);
    add(2, 0, 1, 1, 0, 0, 0, 9, 0);
    add(2, 0, 1, 1, 0, 0, 1, 0, 1);
    add(2, 0, 1, 0, 0, 0, 1, 9, 1);
    add(2, 0, 0, 0, 0, 0, 0, 9, 0);

    for (int i = 0; i < vecs.size(); i++)
      apply_vec(i, vecs[i]);

    // Cascade: after clear, {hi,lo} must track the edge count mod 256.
    @(negedge clk);
    c_clear = 1'b1;
    @(posedge clk);
    #1;
    check("cascade reset", 32'({hi_q, lo_q}), 32'd0);
    @(negedge clk);
    c_clear = 1'b0;
    c_en    = 1'b1;
    c_up    = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      exp_q.push_back(8'(n));
      @(posedge clk);
      #1;
      check($sformatf("cascade edge %0d", n), 32'({hi_q, lo_q}), 32'(exp_q.pop_front()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
